// File: rtl/rv_decode_unit.sv
// Registered RV32 decode stage: splits one instruction into register indices,
// sign-extended immediate, ALU op code and control vector, one cycle latency.
module rv_decode_unit #(
   parameter int unsigned INSTR_SIZE     = 32,
   parameter int unsigned WORD_SIZE      = 32,
   parameter int unsigned NUM_A_REGS     = 32,
   parameter int unsigned ALU_OP_SIZE    = 4,
   parameter int unsigned CONTR_SIG_SIZE = 5,
   parameter logic [ALU_OP_SIZE-1:0] ALU_ADD = 4'b0010,
   parameter logic [ALU_OP_SIZE-1:0] ALU_SUB = 4'b0110,
   parameter logic [ALU_OP_SIZE-1:0] ALU_AND = 4'b0000,
   parameter logic [ALU_OP_SIZE-1:0] ALU_XOR = 4'b1000,
   parameter logic [ALU_OP_SIZE-1:0] ALU_SRA = 4'b1001,
   parameter int unsigned CONTR_VALID_INDEX    = 0,
   parameter int unsigned CONTR_REGWRITE_INDEX = 1,
   parameter int unsigned CONTR_ALUSRC_INDEX   = 2,
   parameter int unsigned CONTR_MEMRE_INDEX    = 3,
   parameter int unsigned CONTR_MEMWR_INDEX    = 4,
   parameter int unsigned RegIdxW = $clog2(NUM_A_REGS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic [INSTR_SIZE-1:0]     instr_i,
   output logic [RegIdxW-1:0]        rd_o,
   output logic [RegIdxW-1:0]        rs1_o,
   output logic [RegIdxW-1:0]        rs2_o,
   output logic [WORD_SIZE-1:0]      imm_o,
   output logic [ALU_OP_SIZE-1:0]    alu_op_o,
   output logic [CONTR_SIG_SIZE-1:0] control_o
);

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] F7Zero  = 7'b0000000;
   localparam logic [6:0] F7Alt   = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   logic [RegIdxW-1:0]        rd_d, rs1_d, rs2_d;
   logic [RegIdxW-1:0]        rd_q, rs1_q, rs2_q;
   logic [WORD_SIZE-1:0]      imm_d, imm_q;
   logic [ALU_OP_SIZE-1:0]    alu_op_d, alu_op_q;
   logic [CONTR_SIG_SIZE-1:0] control_d, control_q;
   logic                      valid, regwrite, alusrc, memre, memwr;
   logic                      use_rs2, use_rd;
   logic [WORD_SIZE-1:0]      imm_i_type, imm_s_type, imm_shamt;

   assign imm_i_type = {{(WORD_SIZE-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_s_type = {{(WORD_SIZE-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_shamt  = {{(WORD_SIZE-5){1'b0}}, instr_i[24:20]};

   // Combinational decode; anything unrecognised falls through as an all-zero bubble.
   always_comb begin
      valid    = 1'b0;
      regwrite = 1'b0;
      alusrc   = 1'b0;
      memre    = 1'b0;
      memwr    = 1'b0;
      use_rs2  = 1'b0;
      use_rd   = 1'b0;
      alu_op_d = ALU_ADD;
      imm_d    = '0;
      unique case (opcode)
         OpR: begin
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            valid   = 1'b1;
            if (funct3 == 3'b000 && funct7 == F7Zero)      alu_op_d = ALU_ADD;
            else if (funct3 == 3'b000 && funct7 == F7Alt)  alu_op_d = ALU_SUB;
            else if (funct3 == 3'b111 && funct7 == F7Zero) alu_op_d = ALU_AND;
            else if (funct3 == 3'b100 && funct7 == F7Zero) alu_op_d = ALU_XOR;
            else if (funct3 == 3'b101 && funct7 == F7Alt)  alu_op_d = ALU_SRA;
            else                                           valid    = 1'b0;
            regwrite = valid;
         end
         OpI: begin
            use_rd   = 1'b1;
            valid    = 1'b1;
            imm_d    = imm_i_type;
            if (funct3 == 3'b000)      alu_op_d = ALU_ADD;
            else if (funct3 == 3'b111) alu_op_d = ALU_AND;
            else if (funct3 == 3'b100) alu_op_d = ALU_XOR;
            else if (funct3 == 3'b101 && funct7 == F7Alt) begin
               alu_op_d = ALU_SRA;
               imm_d    = imm_shamt;
            end else begin
               valid = 1'b0;
            end
            regwrite = valid;
            alusrc   = valid;
         end
         OpLoad: begin
            use_rd   = 1'b1;
            valid    = (funct3 == 3'b010);
            imm_d    = imm_i_type;
            regwrite = valid;
            alusrc   = valid;
            memre    = valid;
         end
         OpStore: begin
            use_rs2 = 1'b1;
            valid   = (funct3 == 3'b010);
            imm_d   = imm_s_type;
            alusrc  = valid;
            memwr   = valid;
         end
         default: ;
      endcase

      rd_d  = (valid && use_rd)  ? instr_i[11:7]  : '0;
      rs1_d = valid              ? instr_i[19:15] : '0;
      rs2_d = (valid && use_rs2) ? instr_i[24:20] : '0;
      if (!valid) begin
         alu_op_d = ALU_ADD;
         imm_d    = '0;
      end
      // x0 is never renamed, so a write to it is suppressed here.
      if (rd_d == '0) regwrite = 1'b0;

      control_d                       = '0;
      control_d[CONTR_VALID_INDEX]    = valid;
      control_d[CONTR_REGWRITE_INDEX] = regwrite;
      control_d[CONTR_ALUSRC_INDEX]   = alusrc;
      control_d[CONTR_MEMRE_INDEX]    = memre;
      control_d[CONTR_MEMWR_INDEX]    = memwr;
   end

   // Output register: capture on en_i, hold on stall, async clear on reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         alu_op_q  <= '0;
         control_q <= '0;
      end else if (en_i) begin
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
         alu_op_q  <= alu_op_d;
         control_q <= control_d;
      end
   end

   assign rd_o      = rd_q;
   assign rs1_o     = rs1_q;
   assign rs2_o     = rs2_q;
   assign imm_o     = imm_q;
   assign alu_op_o  = alu_op_q;
   assign control_o = control_q;

endmodule

// File: tb/tb_rv_decode_unit.sv
// Scoreboard bench for rv_decode_unit: directed vectors push expectations,
// a monitor pops and compares one cycle later.
module tb_rv_decode_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic [4:0]  rd_o, rs1_o, rs2_o;
   logic [31:0] imm_o;
   logic [3:0]  alu_op_o;
   logic [4:0]  control_o;

   typedef struct {
      string       name;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [4:0]  ctrl;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_cmp = 0;
   int   n_bad = 0;

   rv_decode_unit dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .instr_i   (instr_i),
      .rd_o      (rd_o),
      .rs1_o     (rs1_o),
      .rs2_o     (rs2_o),
      .imm_o     (imm_o),
      .alu_op_o  (alu_op_o),
      .control_o (control_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t mk(input string n, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [3:0] alu, input logic [4:0] ctrl);
      exp_t e;
      e.name = n; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu = alu; e.ctrl = ctrl;
      return e;
   endfunction

   task automatic check(input exp_t e);
      n_cmp++;
      if (rd_o !== e.rd || rs1_o !== e.rs1 || rs2_o !== e.rs2 || imm_o !== e.imm ||
          alu_op_o !== e.alu || control_o !== e.ctrl) begin
         n_bad++;
         $display("FAIL %s: got rd=%0d rs1=%0d rs2=%0d imm=%h alu=%b ctrl=%b, want rd=%0d rs1=%0d rs2=%0d imm=%h alu=%b ctrl=%b",
                  e.name, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o,
                  e.rd, e.rs1, e.rs2, e.imm, e.alu, e.ctrl);
      end
   endtask

   // Drive one cycle of stimulus; with en_i low the expected output is the held value.
   task automatic step(input logic [31:0] ins, input logic en, input exp_t e);
      @(negedge clk_i);
      instr_i = ins;
      en_i    = en;
      if (en) last_exp = e;
      sb_q.push_back(last_exp);
   endtask

   // Monitor: every registered output update is checked against the scoreboard head.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (sb_q.size() > 0) check(sb_q.pop_front());
      end
   end

   exp_t e_zero, e_bub, e_add, e_sub;

   initial begin
      e_zero = mk("reset", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0000, 5'b00000);
      e_bub  = mk("bubble", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0010, 5'b00000);
      e_add  = mk("add", 5'd1, 5'd2, 5'd3, 32'h0, 4'b0010, 5'b00011);
      e_sub  = mk("sub", 5'd5, 5'd6, 5'd7, 32'h0, 4'b0110, 5'b00011);
      last_exp = e_zero;

      #2;
      check(e_zero);
      @(negedge clk_i);
      rst_i = 1'b0;

      step(32'h003100B3, 1'b1, e_add);
      step(32'hFFF10093, 1'b1, mk("addi", 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 4'b0010, 5'b00111));
      step(32'h40315093, 1'b1, mk("srai", 5'd1, 5'd2, 5'd0, 32'h3, 4'b1001, 5'b00111));
      step(32'h00812203, 1'b1, mk("lw", 5'd4, 5'd2, 5'd0, 32'h8, 4'b0010, 5'b01111));
      step(32'hFE112E23, 1'b1, mk("sw", 5'd0, 5'd2, 5'd1, 32'hFFFFFFFC, 4'b0010, 5'b10101));
      step(32'h00000000, 1'b1, e_bub);
      step(32'h00A4F433, 1'b1, mk("and", 5'd8, 5'd9, 5'd10, 32'h0, 4'b0000, 5'b00011));
      step(32'h00002033, 1'b1, mk("slt", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0010, 5'b00000));
      step(32'h7FF24193, 1'b1, mk("xori", 5'd3, 5'd4, 5'd0, 32'h7FF, 4'b1000, 5'b00111));
      step(32'h403150B3, 1'b1, mk("sra", 5'd1, 5'd2, 5'd3, 32'h0, 4'b1001, 5'b00011));
      step(32'h00208033, 1'b1, mk("add_x0", 5'd0, 5'd1, 5'd2, 32'h0, 4'b0010, 5'b00001));

      // Stall: sub is presented but must not be captured until en_i returns.
      step(32'h003100B3, 1'b1, e_add);
      for (int i = 0; i < 3; i++) step(32'h407302B3, 1'b0, e_sub);
      step(32'h407302B3, 1'b1, e_sub);

      // Async reset mid-stall, between clock edges.
      step(32'h003100B3, 1'b1, e_add);
      @(negedge clk_i);
      en_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check(mk("async_reset", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0000, 5'b00000));
      en_i = 1'b1;
      @(negedge clk_i);
      check(mk("reset_over_en", 5'd0, 5'd0, 5'd0, 32'h0, 4'b0000, 5'b00000));
      rst_i = 1'b0;
      step(32'h003100B3, 1'b1, e_add);

      // Drain with a bounded wait.
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk_i);
      if (sb_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
      @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
